// File: rtl/data_table_search_bounded_if.sv
// Bundles the task, data-table read port and result channels of the chain search engine.
// The engine binds to the slave modport and the surrounding logic to the master modport.
interface data_table_search_bounded_if #(
  parameter int unsigned KEY_W    = 32,
  parameter int unsigned VALUE_W  = 32,
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned BUCKET_W = 8,
  parameter int unsigned TAG_W    = 8,
  parameter int unsigned MAX_HOPS = 16
);
  localparam int unsigned HOP_W = $clog2(MAX_HOPS + 1);

  logic [KEY_W-1:0]    task_key_i;
  logic [BUCKET_W-1:0] task_bucket_i;
  logic [A_WIDTH-1:0]  task_head_ptr_i;
  logic                task_head_ptr_val_i;
  logic [TAG_W-1:0]    task_tag_i;
  logic                task_valid_i;
  logic                task_ready_o;

  logic                rd_avail_i;
  logic [A_WIDTH-1:0]  rd_addr_o;
  logic                rd_en_o;
  logic [KEY_W-1:0]    rd_data_key_i;
  logic [VALUE_W-1:0]  rd_data_value_i;
  logic [A_WIDTH-1:0]  rd_data_next_ptr_i;
  logic                rd_data_next_ptr_val_i;
  logic                rd_data_val_i;

  logic [KEY_W-1:0]    result_key_o;
  logic [BUCKET_W-1:0] result_bucket_o;
  logic [TAG_W-1:0]    result_tag_o;
  logic [VALUE_W-1:0]  result_found_value_o;
  logic [2:0]          result_chain_state_o;
  logic [1:0]          result_rescode_o;
  logic [HOP_W-1:0]    result_hops_o;
  logic                result_valid_o;
  logic                result_ready_i;

  modport slave (
    input  task_key_i, task_bucket_i, task_head_ptr_i, task_head_ptr_val_i,
           task_tag_i, task_valid_i,
    output task_ready_o,
    input  rd_avail_i,
    output rd_addr_o, rd_en_o,
    input  rd_data_key_i, rd_data_value_i, rd_data_next_ptr_i,
           rd_data_next_ptr_val_i, rd_data_val_i,
    output result_key_o, result_bucket_o, result_tag_o, result_found_value_o,
           result_chain_state_o, result_rescode_o, result_hops_o, result_valid_o,
    input  result_ready_i
  );

  modport master (
    output task_key_i, task_bucket_i, task_head_ptr_i, task_head_ptr_val_i,
           task_tag_i, task_valid_i,
    input  task_ready_o,
    output rd_avail_i,
    input  rd_addr_o, rd_en_o,
    output rd_data_key_i, rd_data_value_i, rd_data_next_ptr_i,
           rd_data_next_ptr_val_i, rd_data_val_i,
    input  result_key_o, result_bucket_o, result_tag_o, result_found_value_o,
           result_chain_state_o, result_rescode_o, result_hops_o, result_valid_o,
    output result_ready_i
  );
endinterface

// File: rtl/data_table_search_bounded.sv
// Hash-table chain search engine: walks a linked chain in data-table RAM one node per read,
// stopping on key match, chain tail, or after MAX_HOPS nodes.
module data_table_search_bounded #(
  parameter int unsigned KEY_W    = 32,
  parameter int unsigned VALUE_W  = 32,
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned BUCKET_W = 8,
  parameter int unsigned TAG_W    = 8,
  parameter int unsigned MAX_HOPS = 16
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  data_table_search_bounded_if.slave bus
);
  localparam int unsigned HOP_W = $clog2(MAX_HOPS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [2:0] CS_NO_CHAIN         = 3'd0;
  localparam logic [2:0] CS_IN_HEAD          = 3'd1;
  localparam logic [2:0] CS_IN_MIDDLE        = 3'd2;
  localparam logic [2:0] CS_IN_TAIL          = 3'd3;
  localparam logic [2:0] CS_IN_TAIL_NO_MATCH = 3'd4;
  localparam logic [2:0] CS_LIMIT_HIT        = 3'd5;

  localparam logic [1:0] RC_FOUND    = 2'd0;
  localparam logic [1:0] RC_NO_ENTRY = 2'd1;
  localparam logic [1:0] RC_LIMIT    = 2'd2;

  localparam logic [HOP_W-1:0] HOPS_MAX = HOP_W'(MAX_HOPS);
  localparam logic [HOP_W-1:0] HOPS_ONE = HOP_W'(1);

  logic [1:0]          state_q;
  logic [KEY_W-1:0]    key_q;
  logic [BUCKET_W-1:0] bucket_q;
  logic [TAG_W-1:0]    tag_q;
  logic [VALUE_W-1:0]  value_q;
  logic [2:0]          chain_q;
  logic [1:0]          rescode_q;
  logic [HOP_W-1:0]    hops_q;
  logic [A_WIDTH-1:0]  rd_addr_q;

  logic key_match;
  logic hop_limit;
  logic issue_fire;

  always_comb begin
    key_match  = (bus.rd_data_key_i == key_q);
    hop_limit  = (hops_q == HOPS_MAX);
    issue_fire = (state_q == S_ISSUE) && bus.rd_avail_i;
  end

  // Handshake outputs are decoded from state so rd_en_o tracks the grant in the same cycle.
  always_comb begin
    bus.task_ready_o         = (state_q == S_IDLE);
    bus.rd_en_o              = issue_fire;
    bus.rd_addr_o            = rd_addr_q;
    bus.result_valid_o       = (state_q == S_REPORT);
    bus.result_key_o         = key_q;
    bus.result_bucket_o      = bucket_q;
    bus.result_tag_o         = tag_q;
    bus.result_found_value_o = value_q;
    bus.result_chain_state_o = chain_q;
    bus.result_rescode_o     = rescode_q;
    bus.result_hops_o        = hops_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      key_q     <= '0;
      bucket_q  <= '0;
      tag_q     <= '0;
      value_q   <= '0;
      chain_q   <= CS_NO_CHAIN;
      rescode_q <= RC_FOUND;
      hops_q    <= '0;
      rd_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.task_valid_i) begin
            key_q     <= bus.task_key_i;
            bucket_q  <= bus.task_bucket_i;
            tag_q     <= bus.task_tag_i;
            hops_q    <= '0;
            value_q   <= '0;
            chain_q   <= CS_NO_CHAIN;
            if (bus.task_head_ptr_val_i) begin
              rescode_q <= RC_FOUND;
              rd_addr_q <= bus.task_head_ptr_i;
              state_q   <= S_ISSUE;
            end else begin
              rescode_q <= RC_NO_ENTRY;
              state_q   <= S_REPORT;
            end
          end
        end

        S_ISSUE: begin
          // WAIT re-enters ISSUE only below the limit, so hops_q cannot pass MAX_HOPS.
          if (issue_fire) begin
            hops_q  <= hops_q + HOPS_ONE;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.rd_data_val_i) begin
            if (key_match) begin
              value_q   <= bus.rd_data_value_i;
              rescode_q <= RC_FOUND;
              if (hops_q == HOPS_ONE)
                chain_q <= CS_IN_HEAD;
              else if (!bus.rd_data_next_ptr_val_i)
                chain_q <= CS_IN_TAIL;
              else
                chain_q <= CS_IN_MIDDLE;
              state_q   <= S_REPORT;
            end else if (!bus.rd_data_next_ptr_val_i) begin
              chain_q   <= CS_IN_TAIL_NO_MATCH;
              rescode_q <= RC_NO_ENTRY;
              state_q   <= S_REPORT;
            end else if (hop_limit) begin
              chain_q   <= CS_LIMIT_HIT;
              rescode_q <= RC_LIMIT;
              state_q   <= S_REPORT;
            end else begin
              rd_addr_q <= bus.rd_data_next_ptr_i;
              state_q   <= S_ISSUE;
            end
          end
        end

        S_REPORT: begin
          if (bus.result_ready_i)
            state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/data_table_search_bounded.md
Name: data_table_search_bounded

Overview:
- Parametrised successor of the hash-table chain search engine.
- Accepts one search task at a time: key, bucket, head pointer and an opaque tag.
- Walks the linked chain in data-table RAM through a single read port and returns found/not-found, the found value, the chain position and the hop count.
- Adds configurable key, value, address and tag widths, single-pulse read issue, and a MAX_HOPS bound that terminates corrupted or looping chains with a distinct result code.

Parameters:
KEY_W, 32, key width in bits
VALUE_W, 32, value width in bits
A_WIDTH, 8, data-table address width
BUCKET_W, 8, bucket index width
TAG_W, 8, opaque per-task tag carried through to the result
MAX_HOPS, 16, maximum chain nodes read per task (≥1); HOP_W = $clog2(MAX_HOPS+1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset
task_key_i  in  KEY_W  search key
task_bucket_i  in  BUCKET_W  bucket index (passthrough)
task_head_ptr_i  in  A_WIDTH  chain head address
task_head_ptr_val_i  in  1  head pointer valid
task_tag_i  in  TAG_W  opaque tag
task_valid_i  in  1  task valid
task_ready_o  out  1  task ready
rd_avail_i  in  1  RAM read port grant available this cycle
rd_addr_o  out  A_WIDTH  read address
rd_en_o  out  1  read request, one-cycle pulse per node
rd_data_key_i  in  KEY_W  node key
rd_data_value_i  in  VALUE_W  node value
rd_data_next_ptr_i  in  A_WIDTH  node next pointer
rd_data_next_ptr_val_i  in  1  next pointer valid
rd_data_val_i  in  1  read data valid
result_key_o  out  KEY_W  locked key
result_bucket_o  out  BUCKET_W  locked bucket
result_tag_o  out  TAG_W  locked tag
result_found_value_o  out  VALUE_W  value of matching node, else 0
result_chain_state_o  out  3  0 NO_CHAIN, 1 IN_HEAD, 2 IN_MIDDLE, 3 IN_TAIL, 4 IN_TAIL_NO_MATCH, 5 LIMIT_HIT
result_rescode_o  out  2  0 SEARCH_FOUND, 1 SEARCH_NOT_SUCCESS_NO_ENTRY, 2 SEARCH_CHAIN_LIMIT
result_hops_o  out  HOP_W  number of nodes read
result_valid_o  out  1  result valid
result_ready_i  in  1  result ready

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_n_i is synchronous and active-low.
- Reset values: state IDLE, task_ready_o=1, rd_en_o=0, rd_addr_o=0, result_valid_o=0, all result fields 0.
- FSM states:
  - IDLE: task_ready_o=1. Accept on task_valid_i&&task_ready_o and lock key/bucket/tag. hops←0, value←0.
    - head_ptr_val=0 → REPORT, chain_state NO_CHAIN, rescode 1.
    - Otherwise rd_addr←head_ptr → ISSUE.
  - ISSUE: rd_en_o = rd_avail_i (combinational). On rd_en_o: hops←hops+1, go to WAIT. Hold ISSUE while rd_avail_i=0.
  - WAIT: rd_en_o=0. On rd_data_val_i:
    - key match → REPORT, rescode 0, value latched. chain_state: IN_HEAD if hops==1; IN_TAIL if hops>1 and next_ptr_val=0; IN_MIDDLE otherwise.
    - Else if next_ptr_val=0 → REPORT, IN_TAIL_NO_MATCH, rescode 1.
    - Else if hops==MAX_HOPS → REPORT, LIMIT_HIT, rescode 2.
    - Else rd_addr←next_ptr → ISSUE.
  - REPORT: result_valid_o=1, all result fields stable. On result_ready_i → IDLE.
- Key match priority: the head node is IN_HEAD even if it is also the tail. A match on the MAX_HOPS-th node reports FOUND, not LIMIT.
- rd_data_val_i outside WAIT is ignored; no state or field changes.
- Exactly one rd_en_o pulse per node. Never more than one outstanding read.
- Latency with rd_avail_i=1 and read latency L: accept at cycle 0, rd_en at cycle 1, data at 1+L. Next rd_en follows 1 cycle after data; result_valid follows 1 cycle after the final data.
- No-head task: result_valid_o at cycle 1.
- Back-to-back: a new task is accepted no earlier than the cycle after result handshake (IDLE cycle required).
- Reset mid-walk: returns to IDLE next edge; a late rd_data_val_i is ignored.
- hops saturates by construction at MAX_HOPS and never wraps.

Test Plan:
- head_ptr_val=0, key=0x55, tag=0x3 → result_valid at cycle 1: rescode 1, NO_CHAIN, hops 0, tag 0x3.
- Chain 10→11→12 (tail), key matches node 12, rd latency 2 → 3 rd_en pulses (addr 10, 11, 12): FOUND, IN_TAIL, hops 3, value of node 12.
- Single-node chain matching the head → FOUND, IN_HEAD, hops 1; with key mismatch → rescode 1, IN_TAIL_NO_MATCH, hops 1.
- MAX_HOPS=4, circular chain 5→6→5→…, no match → exactly 4 rd_en pulses, rescode 2, LIMIT_HIT, hops 4, value 0.
- rd_avail_i low 3 cycles in ISSUE, result_ready_i low 5 cycles in REPORT, stray rd_data_val_i in IDLE → rd_en single pulse after avail rises; result fields stable while valid held; stray data no effect.
- rst_n_i asserted in WAIT, then data arrives → outputs return to reset values, no result emitted, next task processed normally.
